// File: rtl/noc_bridge_pkg.sv
// Shared types and defaults for the NoC bridge AXIS path.
// Holds the packed packet layout, the default widths and the serializer state encoding.
package noc_bridge_pkg;

  // Field order is MSB to LSB as packed onto the AXIS FIFO output.
  typedef struct packed {
    logic [3:0]  data_hdr;
    logic [63:0] data;
    logic [7:0]  data_validity;
    logic [3:0]  credits_hdr;
    logic [19:0] credits;
  } axis_packet_t;

  localparam int DefaultDataWidth = $bits(axis_packet_t);
  localparam int DefaultPhyWidth  = 32;

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/noc_bridge_axis_serializer.sv
// Splits a packed bridge packet into PhyWidth beats, LSB first, with zero-bubble packet chaining.
// Define NOC_BRIDGE_SER_PARITY_EN to append an even-parity bit as the MSB of each beat.
module noc_bridge_axis_serializer
  import noc_bridge_pkg::*;
#(
  parameter int DataWidth    = DefaultDataWidth,
  parameter int PhyWidth     = DefaultPhyWidth,
  parameter bit IgnoreAssert = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pkt_valid_i,
  output logic                 pkt_ready_o,
  input  logic [DataWidth-1:0] pkt_data_i,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
`ifdef NOC_BRIDGE_SER_PARITY_EN
  output logic [PhyWidth:0]    beat_data_o,
`else
  output logic [PhyWidth-1:0]  beat_data_o,
`endif
  output logic                 beat_last_o,
  output logic                 busy_o
);

  localparam int NumBeats   = ceil_div(DataWidth, PhyWidth);
  localparam int ShiftWidth = NumBeats * PhyWidth;
  localparam int CntWidth   = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumBeats - 1);

  ser_state_e            state_q;
  logic [ShiftWidth-1:0] shift_q;
  logic [ShiftWidth-1:0] pkt_padded;
  logic [CntWidth-1:0]   cnt_q;
  logic [CntWidth-1:0]   cnt_next;
  logic [PhyWidth-1:0]   payload;
  logic                  accept;
  logic                  beat_fire;

  // Bits above DataWidth stay zero so the final beat is zero-padded.
  always_comb begin
    pkt_padded                  = '0;
    pkt_padded[DataWidth-1:0]   = pkt_data_i;
  end

  // A new packet may only enter while idle or while the final beat is leaving.
  assign pkt_ready_o = ~rst_i & ((state_q == SER_IDLE) | (beat_last_o & beat_ready_i));
  assign accept      = pkt_valid_i & pkt_ready_o;
  assign beat_fire   = beat_valid_o & beat_ready_i;
  assign cnt_next    = cnt_q + CntWidth'(1);
  assign payload     = shift_q[PhyWidth-1:0];

`ifdef NOC_BRIDGE_SER_PARITY_EN
  assign beat_data_o = {^payload, payload};
`else
  assign beat_data_o = payload;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= SER_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      beat_valid_o <= 1'b0;
      beat_last_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else if (accept) begin
      state_q      <= SER_SEND;
      shift_q      <= pkt_padded;
      cnt_q        <= '0;
      beat_valid_o <= 1'b1;
      beat_last_o  <= (NumBeats == 1);
      busy_o       <= 1'b1;
    end else if (beat_fire) begin
      if (beat_last_o) begin
        state_q      <= SER_IDLE;
        shift_q      <= '0;
        cnt_q        <= '0;
        beat_valid_o <= 1'b0;
        beat_last_o  <= 1'b0;
        busy_o       <= 1'b0;
      end else begin
        shift_q     <= shift_q >> PhyWidth;
        cnt_q       <= cnt_next;
        beat_last_o <= (cnt_next == LastCnt);
      end
    end
  end

  if (!IgnoreAssert) begin : g_assert
    // A stalled beat must not change underneath the downstream consumer.
    stable_under_backpressure: assert property (
      @(posedge clk_i) disable iff (rst_i)
      (beat_valid_o && !beat_ready_i) |=>
        (beat_valid_o && $stable(beat_data_o) && $stable(beat_last_o))
    );
  end

endmodule

// File: tb/tb_noc_bridge_axis_serializer.sv
// Scoreboard bench for noc_bridge_axis_serializer: expected beats are queued at packet
// acceptance and popped by a monitor on every beat handshake.
module tb_noc_bridge_axis_serializer;

  localparam int DW = 100;
  localparam int PW = 32;
  localparam int NB = 4;
`ifdef NOC_BRIDGE_SER_PARITY_EN
  localparam int OUTW = PW + 1;
`else
  localparam int OUTW = PW;
`endif

  typedef struct {
    logic [OUTW-1:0] data;
    logic            last;
  } beat_t;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            pkt_valid_i;
  logic            pkt_ready_o;
  logic [DW-1:0]   pkt_data_i;
  logic            beat_valid_o;
  logic            beat_ready_i;
  logic [OUTW-1:0] beat_data_o;
  logic            beat_last_o;
  logic            busy_o;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    rand_ready = 1'b0;

  noc_bridge_axis_serializer #(.DataWidth(DW), .PhyWidth(PW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pkt_valid_i  (pkt_valid_i),
    .pkt_ready_o  (pkt_ready_o),
    .pkt_data_i   (pkt_data_i),
    .beat_valid_o (beat_valid_o),
    .beat_ready_i (beat_ready_i),
    .beat_data_o  (beat_data_o),
    .beat_last_o  (beat_last_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [OUTW-1:0] exp_beat(input logic [DW-1:0] p, input int k);
    logic [NB*PW-1:0] padded;
    logic [PW-1:0]    pl;
    padded         = '0;
    padded[DW-1:0] = p;
    pl             = padded[k*PW +: PW];
`ifdef NOC_BRIDGE_SER_PARITY_EN
    return {^pl, pl};
`else
    return pl;
`endif
  endfunction

  function automatic logic [DW-1:0] rand_pkt();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic push_pkt(input logic [DW-1:0] p);
    for (int k = 0; k < NB; k++) exp_q.push_back('{exp_beat(p, k), (k == NB - 1)});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_ready) beat_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  // Offers one packet; returns one step after the accepting edge, i.e. in the first beat cycle.
  task automatic drive_pkt(input logic [DW-1:0] p, input bit push);
    bit acc = 1'b0;
    pkt_data_i  = p;
    pkt_valid_i = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk_i);
      if (pkt_ready_o) begin
        acc = 1'b1;
        if (push) push_pkt(p);
      end
      tick();
    end
    pkt_valid_i = 1'b0;
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("[TB] FAIL pkt_accept: got no acceptance, want acceptance within 200 cycles");
    end
  endtask

  task automatic wait_drain(input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && !busy_o) done = 1'b1;
      else tick();
    end
    if (done) tick();
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL drain: got %0d beats pending busy=%0b, want 0 and busy=0", exp_q.size(), busy_o);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && beat_valid_o && beat_ready_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL beat_unexpected: got beat %h, want no beat", beat_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (beat_data_o !== mon_e.data) begin
          n_fail++;
          $display("[TB] FAIL beat_data: got %h, want %h", beat_data_o, mon_e.data);
        end
        n_checks++;
        if (beat_last_o !== mon_e.last) begin
          n_fail++;
          $display("[TB] FAIL beat_last: got %0b, want %0b", beat_last_o, mon_e.last);
        end
      end
    end
  end

  task automatic test_reset();
    #2;
    n_checks += 4;
    if (pkt_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pkt_ready: got %b want 0", pkt_ready_o); end
    if (beat_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_beat_valid: got %b want 0", beat_valid_o); end
    if (beat_last_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_beat_last: got %b want 0", beat_last_o); end
    if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    n_checks += 2;
    if (pkt_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_pkt_ready: got %b want 1", pkt_ready_o); end
    if (beat_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_beat_valid: got %b want 0", beat_valid_o); end
    tick();
  endtask

  task automatic test_single();
    logic [DW-1:0] p;
    p = 100'h0_0000000F_DEADBEEF_12345678;
    beat_ready_i = 1'b1;
    exp_q.push_back('{OUTW'(32'h12345678), 1'b0});
    exp_q.push_back('{OUTW'(32'hDEADBEEF), 1'b0});
    exp_q.push_back('{OUTW'(32'h0000000F), 1'b0});
    exp_q.push_back('{OUTW'(32'h00000000), 1'b1});
`ifdef NOC_BRIDGE_SER_PARITY_EN
    exp_q[0].data[PW] = ^exp_q[0].data[PW-1:0];
    exp_q[1].data[PW] = ^exp_q[1].data[PW-1:0];
    exp_q[2].data[PW] = ^exp_q[2].data[PW-1:0];
`endif
    drive_pkt(p, 1'b0);
    n_checks += 2;
    if (beat_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL first_beat_latency: got valid %b want 1", beat_valid_o); end
    if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL send_busy: got %b want 1", busy_o); end
    wait_drain(20);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] pa, pb;
    bit acc_a = 1'b0;
    bit acc_b = 1'b0;
    pa = rand_pkt();
    pb = rand_pkt();
    beat_ready_i = 1'b1;
    pkt_data_i   = pa;
    pkt_valid_i  = 1'b1;
    for (int i = 0; i < 20 && !acc_a; i++) begin
      @(negedge clk_i);
      if (pkt_ready_o) begin acc_a = 1'b1; push_pkt(pa); end
      tick();
    end
    pkt_data_i = pb;
    for (int i = 0; i < 2 * NB; i++) begin
      @(negedge clk_i);
      n_checks += 2;
      if (beat_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_gap: beat %0d valid got %b want 1", i, beat_valid_o); end
      if (beat_last_o !== (i == NB - 1 || i == 2 * NB - 1)) begin
        n_fail++;
        $display("[TB] FAIL b2b_last: beat %0d got %b want %0b", i, beat_last_o, (i == NB - 1 || i == 2 * NB - 1));
      end
      if (pkt_valid_i && pkt_ready_o) begin acc_b = 1'b1; push_pkt(pb); end
      tick();
      if (acc_b) pkt_valid_i = 1'b0;
    end
    pkt_valid_i = 1'b0;
    n_checks++;
    if (!(acc_a && acc_b)) begin n_fail++; $display("[TB] FAIL b2b_accept: got a=%0b b=%0b want 1 1", acc_a, acc_b); end
    wait_drain(20);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] p;
    p = rand_pkt();
    beat_ready_i = 1'b1;
    drive_pkt(p, 1'b1);
    tick();
    beat_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_checks += 4;
      if (beat_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_valid: got %b want 1", beat_valid_o); end
      if (beat_data_o !== exp_beat(p, 1)) begin n_fail++; $display("[TB] FAIL stall_data: got %h want %h", beat_data_o, exp_beat(p, 1)); end
      if (beat_last_o !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_last: got %b want 0", beat_last_o); end
      if (pkt_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_pkt_ready: got %b want 0", pkt_ready_o); end
      tick();
    end
    beat_ready_i = 1'b1;
    wait_drain(20);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] p;
    p = rand_pkt();
    beat_ready_i = 1'b1;
    drive_pkt(p, 1'b1);
    tick();
    tick();
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    n_checks += 3;
    if (beat_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_valid: got %b want 0", beat_valid_o); end
    if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b want 0", busy_o); end
    if (pkt_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_pkt_ready: got %b want 0", pkt_ready_o); end
    #1;
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (pkt_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL postrst_pkt_ready: got %b want 1", pkt_ready_o); end
    p = rand_pkt();
    drive_pkt(p, 1'b1);
    n_checks += 2;
    if (beat_data_o !== exp_beat(p, 0)) begin n_fail++; $display("[TB] FAIL postrst_beat0: got %h want %h", beat_data_o, exp_beat(p, 0)); end
    if (beat_last_o !== 1'b0) begin n_fail++; $display("[TB] FAIL postrst_last: got %b want 0", beat_last_o); end
    wait_drain(20);
  endtask

  task automatic test_parity();
`ifdef NOC_BRIDGE_SER_PARITY_EN
    logic [DW-1:0] p;
    p        = '0;
    p[31:0]  = 32'h00000007;
    p[63:32] = 32'h00000003;
    beat_ready_i = 1'b1;
    drive_pkt(p, 1'b1);
    n_checks++;
    if (beat_data_o[PW] !== 1'b1) begin n_fail++; $display("[TB] FAIL parity_odd: got %b want 1", beat_data_o[PW]); end
    tick();
    n_checks++;
    if (beat_data_o[PW] !== 1'b0) begin n_fail++; $display("[TB] FAIL parity_even: got %b want 0", beat_data_o[PW]); end
    wait_drain(20);
`endif
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      pkt_valid_i = 1'b0;
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      drive_pkt(rand_pkt(), 1'b1);
    end
    wait_drain(200);
    rand_ready   = 1'b0;
    beat_ready_i = 1'b1;
  endtask

  initial begin
    rst_i        = 1'b1;
    pkt_valid_i  = 1'b0;
    pkt_data_i   = '0;
    beat_ready_i = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_parity();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL leftover_beats: got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
